// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the two issue lanes. Conflicting
// requests are served lane 0 first, then lane 1 from a holding register.
module dmem_port_arbiter #(
   parameter int                     ADDR_WIDTH   = 16,
   parameter int                     DATA_WIDTH   = 32,
   parameter int                     MEM_OP_BITS  = 2,
   parameter logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'd0,
   parameter logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'd1,
   parameter logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'd2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [MEM_OP_BITS-1:0] mem_op0,
   input  logic [ADDR_WIDTH-1:0]  address0,
   input  logic [DATA_WIDTH-1:0]  write_data0,
   input  logic [MEM_OP_BITS-1:0] mem_op1,
   input  logic [ADDR_WIDTH-1:0]  address1,
   input  logic [DATA_WIDTH-1:0]  write_data1,
   output logic [MEM_OP_BITS-1:0] ram_mem_op,
   output logic [ADDR_WIDTH-1:0]  ram_address,
   output logic [DATA_WIDTH-1:0]  ram_write_data,
   input  logic [DATA_WIDTH-1:0]  ram_read_data,
   output logic [DATA_WIDTH-1:0]  read_data0,
   output logic [DATA_WIDTH-1:0]  read_data1,
   output logic                   stall,
   output logic [15:0]            conflict_count
);

   typedef enum logic {PASS, REPLAY} state_e;

   state_e                 state_q, state_d;
   logic [MEM_OP_BITS-1:0] hold_op_q, hold_op_d;
   logic [ADDR_WIDTH-1:0]  hold_addr_q, hold_addr_d;
   logic [DATA_WIDTH-1:0]  hold_wdata_q, hold_wdata_d;
   logic [DATA_WIDTH-1:0]  rd0_q, rd0_d;
   logic [15:0]            conflict_count_q, conflict_count_d;

   logic req0, req1, same_read;

   assign req0      = (mem_op0 != MEM_OP_NOP);
   assign req1      = (mem_op1 != MEM_OP_NOP);
   assign same_read = (mem_op0 == MEM_OP_READ) && (mem_op1 == MEM_OP_READ) &&
                      (address0 == address1);

   always_comb begin
      // NOTE: every output and next-state value gets a default first, so no path
      // through the case/if tree leaves a signal unassigned and infers a latch.
      state_d          = state_q;
      hold_op_d        = hold_op_q;
      hold_addr_d      = hold_addr_q;
      hold_wdata_d     = hold_wdata_q;
      rd0_d            = rd0_q;
      conflict_count_d = conflict_count_q;
      ram_mem_op       = MEM_OP_NOP;
      ram_address      = '0;
      ram_write_data   = '0;
      read_data0       = ram_read_data;
      read_data1       = ram_read_data;
      stall            = 1'b0;

      unique case (state_q)
         PASS: begin
            if (req0 && req1 && !same_read) begin
               ram_mem_op     = mem_op0;
               ram_address    = address0;
               ram_write_data = write_data0;
               stall          = 1'b1;
               hold_op_d      = mem_op1;
               hold_addr_d    = address1;
               hold_wdata_d   = write_data1;
               rd0_d          = ram_read_data;
               if (conflict_count_q != 16'hFFFF)
                  conflict_count_d = conflict_count_q + 16'd1;
               state_d        = REPLAY;
            end else if (req0) begin
               // Also covers the shared-address dual read: one ram access feeds both lanes.
               ram_mem_op     = mem_op0;
               ram_address    = address0;
               ram_write_data = write_data0;
            end else if (req1) begin
               ram_mem_op     = mem_op1;
               ram_address    = address1;
               ram_write_data = write_data1;
            end
         end
         REPLAY: begin
            ram_mem_op     = hold_op_q;
            ram_address    = hold_addr_q;
            ram_write_data = hold_wdata_q;
            read_data0     = rd0_q;
            state_d        = PASS;
         end
         default: state_d = PASS;
      endcase

      // The held lane 1 request must not reach the ram during reset.
      if (reset) begin
         ram_mem_op     = MEM_OP_NOP;
         ram_address    = '0;
         ram_write_data = '0;
         read_data0     = '0;
         read_data1     = '0;
         stall          = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values and simulation matches the synthesized registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= PASS;
         hold_op_q        <= MEM_OP_NOP;
         hold_addr_q      <= '0;
         hold_wdata_q     <= '0;
         rd0_q            <= '0;
         conflict_count_q <= '0;
      end else begin
         state_q          <= state_d;
         hold_op_q        <= hold_op_d;
         hold_addr_q      <= hold_addr_d;
         hold_wdata_q     <= hold_wdata_d;
         rd0_q            <= rd0_d;
         conflict_count_q <= conflict_count_d;
      end
   end

   assign conflict_count = conflict_count_q;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single data-memory port between the two execution lanes of the dual-issue pipeline; both lanes present memory requests from EX/MEM. Non-conflicting requests pass straight through in the same cycle. Conflicting requests are serialized in program order (lane 0 first): the block stalls the pipeline for one cycle and replays lane 1 from a holding register. It sits between the EX/MEM register outputs and the data `ram`, and drives a stall that the team ORs into the pipeline stall net.

## Interface
- ADDR_WIDTH, default `ADDR_WIDTH, ram address width
- DATA_WIDTH, default `DATA_WIDTH, data word width
- MEM_OP_BITS, default `MEM_OP_BITS, memory op encoding width (`MEM_OP_NOP / read / write codes from defines.vh)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- mem_op0  input  MEM_OP_BITS  lane 0 op; a request is any value != `MEM_OP_NOP
- address0  input  ADDR_WIDTH  lane 0 address
- write_data0  input  DATA_WIDTH  lane 0 store data
- mem_op1 / address1 / write_data1  input  as lane 0  lane 1 request
- ram_mem_op  output  MEM_OP_BITS  op driven to ram
- ram_address  output  ADDR_WIDTH  address driven to ram
- ram_write_data  output  DATA_WIDTH  store data driven to ram
- ram_read_data  input  DATA_WIDTH  combinational read data from ram
- read_data0  output  DATA_WIDTH  load result for lane 0
- read_data1  output  DATA_WIDTH  load result for lane 1
- stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; inhibit MEM/WB capture
- conflict_count  output  16  saturating count of serialized conflicts

## Operation
- Two states: PASS, REPLAY. Registers: state, hold_op/hold_addr/hold_wdata (lane 1 request), rd0_q (lane 0 read result), conflict_count.
- PASS, no requests: ram_mem_op = NOP, read_data0/1 = ram_read_data, stall = 0.
- PASS, only lane k requests: drive lane k to ram; read_data_k = ram_read_data; stall = 0.
- PASS, both request, both reads, address0 == address1: single ram read; read_data0 = read_data1 = ram_read_data; stall = 0; no conflict counted.
- PASS, any other dual request (different addresses, or any write involved): conflict.
  - Drive lane 0 to ram; stall = 1.
  - At the edge: capture lane 1 into hold regs, ram_read_data into rd0_q, increment conflict_count (hold at 16'hFFFF), go to REPLAY.
- REPLAY: drive the hold regs to ram; read_data0 = rd0_q; read_data1 = ram_read_data; stall = 0; the lane-0 inputs are ignored. Next state is PASS unconditionally.
- Ordering guarantee: a lane 1 read after a lane 0 write to the same address returns the new data. For two writes to the same address, lane 1's value is final.
- Pass-through paths are combinational; the RAM read is asynchronous, so results appear in the same cycle as the request.
- In reset, or while reset is asserted: ram_mem_op = NOP, read_data0/1 = 0, stall = 0.

## Timing
- Reset (synchronous, edge with reset = 1): state = PASS, hold_op = NOP, hold_addr/hold_wdata = 0, rd0_q = 0, conflict_count = 0.
- Reset in REPLAY: the held lane 1 request is dropped and never issued; next cycle is PASS.
- Non-conflicting latency: 0 cycles (same-cycle pass-through); stall never asserted.
- Conflict latency: exactly 1 stall cycle. Cycle N: lane 0 is served, stall = 1. Cycle N+1: lane 1 is served, both read results are valid, stall = 0.
- While stall = 1, the upstream EX/MEM outputs hold by contract. In REPLAY they are not re-sampled, so the same request pair cannot cause a second conflict.
- stall is never high for two consecutive cycles.
- conflict_count saturates at 16'hFFFF; no wrap.

## Test plan
- Reset, then idle: all outputs 0/NOP and stall = 0; lane 0 read of 0x0010 holding 0xDEADBEEF gives read_data0 = 0xDEADBEEF the same cycle, stall = 0.
- Lane 0 reads 0x0004 (=0x11) and lane 1 reads 0x0008 (=0x22) together: stall = 1 for one cycle; next cycle read_data0 = 0x11, read_data1 = 0x22; conflict_count = 1.
- Both lanes read 0x0020 (=0x55): no stall; read_data0 = read_data1 = 0x55; conflict_count unchanged.
- Lane 0 writes 0xAAAA to 0x0030 while lane 1 reads 0x0030: stall for one cycle, then read_data1 = 0xAAAA. Both lanes writing 0x0030 (0x1 then 0x2) leaves mem[0x30] = 0x2.
- Conflict, then reset asserted in the REPLAY cycle: the ram sees no lane 1 op, a write held in REPLAY never lands, state returns to PASS, and conflict_count = 0.
- Force 65 540 conflicts: conflict_count holds at 16'hFFFF, and every conflict still produces exactly one stall cycle.
